// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared widths, opcode/ALU/state enums for the CPU sequencer
package cpuConfig;

    localparam int P_SIZE = 5;
    localparam int O_SIZE = 4;
    localparam int A_SIZE = 2;

    typedef enum logic [O_SIZE-1:0] {
        NOP   = 4'd0,
        LDI   = 4'd1,
        LDS   = 4'd2,
        ADD   = 4'd3,
        ADDI  = 4'd4,
        MUL   = 4'd5,
        MULI  = 4'd6,
        WAIT0 = 4'd7,
        WAIT1 = 4'd8
    } opCode_t;

    typedef enum logic [A_SIZE-1:0] {
        ALU_A   = 2'd0,
        ALU_B   = 2'd1,
        ALU_ADD = 2'd2,
        ALU_MUL = 2'd3
    } aluFunc_t;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXEC    = 2'd1,
        MULWAIT = 2'd2,
        STALL   = 2'd3
    } seqState_t;

endpackage

// File: rtl/cpu_sequencer_sync2.sv
// rtl/cpu_sequencer_sync2.sv - two-flop synchroniser for a single asynchronous level
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_ff1;
    logic r_ff2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ff1 <= 1'b0;
            r_ff2 <= 1'b0;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - FETCH/EXEC instruction sequencer with multiplier and SW8 wait handling
module cpu_sequencer #(
    parameter int P_SIZE = cpuConfig::P_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  cpuConfig::opCode_t  opCode,
    input  logic                sw8,
    input  logic                mulDone,
    output logic [P_SIZE-1:0]   pc,
    output cpuConfig::aluFunc_t aluFunc,
    output logic                immSel,
    output logic                swSel,
    output logic                regWe,
    output logic                mulStart,
    output logic                illegal
);

    import cpuConfig::*;

    seqState_t         r_state;
    seqState_t         w_next;
    logic [P_SIZE-1:0] r_pc;
    logic              r_illegal;
    logic              w_pc_inc;
    logic              w_set_illegal;
    logic              w_sw8;

    sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .i_d   (sw8),
        .o_q   (w_sw8)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_pc      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pc_inc)
                r_pc <= r_pc + {{(P_SIZE-1){1'b0}}, 1'b1};
            if (w_set_illegal)
                r_illegal <= 1'b1;
        end
    end

    // pc is held through MULWAIT/STALL, so opCode stays valid for decode there
    always_comb begin
        w_next        = r_state;
        w_pc_inc      = 1'b0;
        w_set_illegal = 1'b0;
        aluFunc       = ALU_A;
        immSel        = 1'b0;
        swSel         = 1'b0;
        regWe         = 1'b0;
        mulStart      = 1'b0;
        case (r_state)
            FETCH: w_next = EXEC;
            EXEC: begin
                case (opCode)
                    NOP: begin
                        w_pc_inc = 1'b1;
                        w_next   = FETCH;
                    end
                    LDI: begin
                        aluFunc  = ALU_B;
                        immSel   = 1'b1;
                        regWe    = 1'b1;
                        w_pc_inc = 1'b1;
                        w_next   = FETCH;
                    end
                    LDS: begin
                        aluFunc  = ALU_B;
                        swSel    = 1'b1;
                        regWe    = 1'b1;
                        w_pc_inc = 1'b1;
                        w_next   = FETCH;
                    end
                    ADD, ADDI: begin
                        aluFunc  = ALU_ADD;
                        immSel   = (opCode == ADDI);
                        regWe    = 1'b1;
                        w_pc_inc = 1'b1;
                        w_next   = FETCH;
                    end
                    MUL, MULI: begin
                        aluFunc  = ALU_MUL;
                        immSel   = (opCode == MULI);
                        mulStart = 1'b1;
                        w_next   = MULWAIT;
                    end
                    WAIT0, WAIT1: begin
                        if (w_sw8 == (opCode == WAIT1)) begin
                            w_pc_inc = 1'b1;
                            w_next   = FETCH;
                        end else begin
                            w_next = STALL;
                        end
                    end
                    default: begin
                        w_set_illegal = 1'b1;
                        w_pc_inc      = 1'b1;
                        w_next        = FETCH;
                    end
                endcase
            end
            MULWAIT: begin
                aluFunc = ALU_MUL;
                immSel  = (opCode == MULI);
                if (mulDone) begin
                    regWe    = 1'b1;
                    w_pc_inc = 1'b1;
                    w_next   = FETCH;
                end
            end
            STALL: begin
                if (w_sw8 == (opCode == WAIT1)) begin
                    w_pc_inc = 1'b1;
                    w_next   = FETCH;
                end
            end
            default: w_next = FETCH;
        endcase
        // reset overrides decode so an in-flight MUL completion cannot write
        if (reset) begin
            aluFunc  = ALU_A;
            immSel   = 1'b0;
            swSel    = 1'b0;
            regWe    = 1'b0;
            mulStart = 1'b0;
        end
    end

    assign pc      = r_pc;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpuConfig::*;

    logic       clk;
    logic       reset;
    opCode_t    opCode;
    logic       sw8;
    logic       mulDone;
    logic [4:0] pc;
    aluFunc_t   aluFunc;
    logic       immSel;
    logic       swSel;
    logic       regWe;
    logic       mulStart;
    logic       illegal;

    logic [3:0] mem [0:31];
    int checks = 0;
    int errors = 0;

    cpu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .opCode   (opCode),
        .sw8      (sw8),
        .mulDone  (mulDone),
        .pc       (pc),
        .aluFunc  (aluFunc),
        .immSel   (immSel),
        .swSel    (swSel),
        .regWe    (regWe),
        .mulStart (mulStart),
        .illegal  (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk) opCode <= opCode_t'(mem[pc]);

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 32; i++) mem[i] = 4'd0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        mulDone = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        fill_nop();
        mem[0]  = 4'd1;
        sw8     = 1'b1;
        mulDone = 1'b1;
        reset   = 1'b1;
        tick();
        tick();
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
        checks++; if (regWe !== 1'b0) begin errors++; $display("FAIL reset_regWe got %0d want 0", regWe); end
        checks++; if (mulStart !== 1'b0) begin errors++; $display("FAIL reset_mulStart got %0d want 0", mulStart); end
        checks++; if (aluFunc !== ALU_A) begin errors++; $display("FAIL reset_aluFunc got %0d want 0", aluFunc); end
        checks++; if ({immSel, swSel} !== 2'b00) begin errors++; $display("FAIL reset_sel got %0d want 0", {immSel, swSel}); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0d want 0", illegal); end
        mulDone = 1'b0;
        sw8     = 1'b0;
    endtask

    task automatic test_single_cycle();
        int       exp_pc  [11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
        logic     exp_we  [11] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0};
        logic     exp_imm [11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        logic     exp_sw  [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        aluFunc_t exp_alu [11] = '{ALU_A, ALU_B, ALU_A, ALU_ADD, ALU_A, ALU_A,
                                   ALU_A, ALU_B, ALU_A, ALU_ADD, ALU_A};
        fill_nop();
        mem[0] = 4'd1;
        mem[1] = 4'd3;
        mem[2] = 4'd0;
        mem[3] = 4'd2;
        mem[4] = 4'd4;
        sw8    = 1'b0;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (i > 0) tick();
            checks++; if (pc !== 5'(exp_pc[i])) begin errors++; $display("FAIL seq_pc[%0d] got %0d want %0d", i, pc, exp_pc[i]); end
            checks++; if (regWe !== exp_we[i]) begin errors++; $display("FAIL seq_regWe[%0d] got %0d want %0d", i, regWe, exp_we[i]); end
            checks++; if (aluFunc !== exp_alu[i]) begin errors++; $display("FAIL seq_alu[%0d] got %0d want %0d", i, aluFunc, exp_alu[i]); end
            checks++; if ({immSel, swSel} !== {exp_imm[i], exp_sw[i]}) begin errors++; $display("FAIL seq_sel[%0d] got %0d want %0d", i, {immSel, swSel}, {exp_imm[i], exp_sw[i]}); end
        end
    endtask

    task automatic test_mul();
        fill_nop();
        mem[4] = 4'd6;
        do_reset();
        for (int i = 0; i < 9; i++) tick();
        mulDone = 1'b1;
        #1;
        checks++; if (mulStart !== 1'b1) begin errors++; $display("FAIL mul_start got %0d want 1", mulStart); end
        checks++; if (regWe !== 1'b0) begin errors++; $display("FAIL mul_exec_regWe got %0d want 0", regWe); end
        checks++; if ({aluFunc, immSel} !== {ALU_MUL, 1'b1}) begin errors++; $display("FAIL mul_exec_alu got %0d want 7", {aluFunc, immSel}); end
        checks++; if (pc !== 5'd4) begin errors++; $display("FAIL mul_exec_pc got %0d want 4", pc); end
        tick();
        mulDone = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick();
            checks++; if ({mulStart, regWe} !== 2'b00) begin errors++; $display("FAIL mul_wait_ctl[%0d] got %0d want 0", i, {mulStart, regWe}); end
            checks++; if ({aluFunc, immSel} !== {ALU_MUL, 1'b1}) begin errors++; $display("FAIL mul_wait_alu[%0d] got %0d want 7", i, {aluFunc, immSel}); end
            checks++; if (pc !== 5'd4) begin errors++; $display("FAIL mul_wait_pc[%0d] got %0d want 4", i, pc); end
        end
        tick();
        mulDone = 1'b1;
        #1;
        checks++; if (regWe !== 1'b1) begin errors++; $display("FAIL mul_done_regWe got %0d want 1", regWe); end
        checks++; if (pc !== 5'd4) begin errors++; $display("FAIL mul_done_pc got %0d want 4", pc); end
        tick();
        mulDone = 1'b0;
        #1;
        checks++; if (pc !== 5'd5) begin errors++; $display("FAIL mul_after_pc got %0d want 5", pc); end
        checks++; if (regWe !== 1'b0) begin errors++; $display("FAIL mul_after_regWe got %0d want 0", regWe); end
    endtask

    task automatic test_wait();
        int n;
        fill_nop();
        mem[0] = 4'd8;
        mem[1] = 4'd8;
        mem[2] = 4'd7;
        sw8    = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({pc, regWe} !== 6'd0) begin errors++; $display("FAIL stall_hold[%0d] got %0d want 0", i, {pc, regWe}); end
        end
        sw8 = 1'b1;
        n   = 0;
        while (pc !== 5'd1 && n < 8) begin
            tick();
            n++;
        end
        checks++; if (n < 2 || n > 3) begin errors++; $display("FAIL stall_release got %0d want 3", n); end
        tick();
        tick();
        checks++; if (pc !== 5'd2) begin errors++; $display("FAIL wait1_pass got %0d want 2", pc); end
        tick();
        sw8 = 1'b0;
        tick();
        tick();
        checks++; if (pc !== 5'd2) begin errors++; $display("FAIL wait0_stall got %0d want 2", pc); end
        tick();
        checks++; if (pc !== 5'd3) begin errors++; $display("FAIL wait0_release got %0d want 3", pc); end
    endtask

    task automatic test_wrap_illegal();
        fill_nop();
        mem[31] = 4'd4;
        do_reset();
        for (int i = 0; i < 62; i++) tick();
        mem[0] = 4'hC;
        checks++; if (pc !== 5'd31) begin errors++; $display("FAIL wrap_pre_pc got %0d want 31", pc); end
        tick();
        checks++; if ({regWe, immSel, aluFunc} !== {1'b1, 1'b1, ALU_ADD}) begin errors++; $display("FAIL wrap_addi got %0d want 14", {regWe, immSel, aluFunc}); end
        tick();
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL wrap_pc got %0d want 0", pc); end
        tick();
        checks++; if ({regWe, immSel, aluFunc} !== {1'b0, 1'b0, ALU_A}) begin errors++; $display("FAIL illegal_nop got %0d want 0", {regWe, immSel, aluFunc}); end
        tick();
        checks++; if ({pc, illegal} !== {5'd1, 1'b1}) begin errors++; $display("FAIL illegal_set got %0d want 3", {pc, illegal}); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if ({pc, illegal} !== {5'd3, 1'b1}) begin errors++; $display("FAIL illegal_sticky got %0d want 7", {pc, illegal}); end
    endtask

    task automatic test_reset_mulwait();
        fill_nop();
        mem[0] = 4'hC;
        mem[1] = 4'd5;
        do_reset();
        tick();
        tick();
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL rmw_illegal_pre got %0d want 1", illegal); end
        tick();
        checks++; if (mulStart !== 1'b1) begin errors++; $display("FAIL rmw_start got %0d want 1", mulStart); end
        tick();
        reset   = 1'b1;
        mulDone = 1'b1;
        #1;
        checks++; if (regWe !== 1'b0) begin errors++; $display("FAIL rmw_regWe got %0d want 0", regWe); end
        tick();
        reset   = 1'b0;
        mulDone = 1'b0;
        #1;
        checks++; if ({pc, illegal, regWe, mulStart} !== 8'd0) begin errors++; $display("FAIL rmw_after got %0d want 0", {pc, illegal, regWe, mulStart}); end
        tick();
        checks++; if (pc !== 5'd0) begin errors++; $display("FAIL rmw_fetch got %0d want 0", pc); end
        tick();
        checks++; if (pc !== 5'd1) begin errors++; $display("FAIL rmw_resume got %0d want 1", pc); end
    endtask

    initial begin
        reset   = 1'b1;
        sw8     = 1'b0;
        mulDone = 1'b0;
        fill_nop();
        test_reset();
        test_single_cycle();
        test_mul();
        test_wait();
        test_wrap_illegal();
        test_reset_mulwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
